// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-port arbiter and access sequencer for a word-wide data memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [2:0]  p0_funct3,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_done,
    output logic        p0_err,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [2:0]  p1_funct3,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_done,
    output logic        p1_err,
    output logic [31:0] p1_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_WR     = 3'd2,
        S_RMW_RD = 3'd3,
        S_RMW_WR = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t      r_state;
    logic        r_last;     // 1 = port 1 was granted last
    logic        r_port;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_word;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_idle;
    logic        w_any;
    logic        w_pick1;
    logic        w_we;
    logic [2:0]  w_funct3;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_illegal;
    logic        w_done;

    function automatic logic f_illegal(input logic we, input logic [2:0] f3,
                                       input logic [1:0] a);
        logic v_bad;
        case (f3)
            3'b000:  v_bad = 1'b0;
            3'b001:  v_bad = a[0];
            3'b010:  v_bad = |a;
            3'b100:  v_bad = we;
            3'b101:  v_bad = we | a[0];
            default: v_bad = 1'b1;
        endcase
        return v_bad;
    endfunction

    function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [1:0] lane,
                                           input logic [31:0] word);
        logic [31:0] v_sh;
        logic [31:0] v_out;
        v_sh = word >> {lane, 3'b000};
        case (f3)
            3'b000:  v_out = {{24{v_sh[7]}}, v_sh[7:0]};
            3'b001:  v_out = {{16{v_sh[15]}}, v_sh[15:0]};
            3'b100:  v_out = {24'd0, v_sh[7:0]};
            3'b101:  v_out = {16'd0, v_sh[15:0]};
            default: v_out = word;
        endcase
        return v_out;
    endfunction

    function automatic logic [31:0] f_merge(input logic [2:0] f3, input logic [1:0] lane,
                                            input logic [31:0] word, input logic [31:0] wd);
        logic [31:0] v_out;
        v_out = word;
        case (f3[1:0])
            2'b00:   v_out[{lane, 3'b000} +: 8] = wd[7:0];
            2'b01:   v_out[{lane[1], 4'b0000} +: 16] = wd[15:0];
            default: v_out = wd;
        endcase
        return v_out;
    endfunction

    // Port 1 wins only when alone, or when round-robin says it is its turn.
    always_comb begin
        w_idle    = (r_state == S_IDLE) && !rst;
        w_any     = p0_req | p1_req;
        w_pick1   = p1_req && (!p0_req || (RR_EN && !r_last));
        p0_gnt    = w_idle && p0_req && !w_pick1;
        p1_gnt    = w_idle && w_pick1;
        w_we      = w_pick1 ? p1_we     : p0_we;
        w_funct3  = w_pick1 ? p1_funct3 : p0_funct3;
        w_addr    = w_pick1 ? p1_addr   : p0_addr;
        w_wdata   = w_pick1 ? p1_wdata  : p0_wdata;
        w_illegal = f_illegal(w_we, w_funct3, w_addr[1:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_last   <= 1'b1;
            r_port   <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_word   <= 32'd0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_port   <= w_pick1;
                        r_last   <= w_pick1;
                        r_funct3 <= w_funct3;
                        r_addr   <= w_addr;
                        r_wdata  <= w_wdata;
                        r_err    <= w_illegal;
                        r_rdata  <= 32'd0;
                        if (w_illegal)
                            r_state <= S_DONE;
                        else if (!w_we)
                            r_state <= S_RD;
                        else if (w_funct3 == 3'b010)
                            r_state <= S_WR;
                        else
                            r_state <= S_RMW_RD;
                    end
                end
                S_RD: begin
                    r_rdata <= f_load(r_funct3, r_addr[1:0], mem_rdata);
                    r_state <= S_DONE;
                end
                S_WR:     r_state <= S_DONE;
                S_RMW_RD: begin
                    r_word  <= mem_rdata;
                    r_state <= S_RMW_WR;
                end
                S_RMW_WR: r_state <= S_DONE;
                S_DONE: begin
                    r_err   <= 1'b0;
                    r_rdata <= 32'd0;
                    r_state <= S_IDLE;
                end
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_done    = (r_state == S_DONE);
        p0_done   = w_done && !r_port;
        p1_done   = w_done && r_port;
        p0_err    = p0_done && r_err;
        p1_err    = p1_done && r_err;
        p0_rdata  = p0_done ? r_rdata : 32'd0;
        p1_rdata  = p1_done ? r_rdata : 32'd0;
        mem_read  = (r_state == S_RD) || (r_state == S_RMW_RD);
        mem_write = (r_state == S_WR) || (r_state == S_RMW_WR);
        mem_addr  = (mem_read || mem_write) ? {r_addr[31:2], 2'b00} : 32'd0;
        case (r_state)
            S_WR:     mem_wdata = r_wdata;
            S_RMW_WR: mem_wdata = f_merge(r_funct3, r_addr[1:0], r_word, r_wdata);
            default:  mem_wdata = 32'd0;
        endcase
        busy      = (r_state != S_IDLE);
    end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Controller that shares the single-port word-wide data memory between two requesters: port 0 (CPU load/store unit) and port 1 (debug/DMA loader).
- Arbitrates the two request ports and sequences each access.
- Turns RISC-V byte and halfword stores into read-modify-write pairs, because the memory writes whole words only.
- Extracts and sign/zero-extends sub-word load data.
- Sits between the requesters and the memory's MemRead/MemWrite/addr/write_data/read_data interface.

Parameters:
- RR_EN, 1, 1 = round-robin arbitration between ports; 0 = fixed priority, port 0 wins.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- p0_req  in  1  port 0 request; held until granted.
- p0_we  in  1  1 = store, 0 = load.
- p0_funct3  in  3  RISC-V width code. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- p0_addr  in  32  byte address.
- p0_wdata  in  32  store data, right-aligned.
- p0_gnt  out  1  request accepted this cycle.
- p0_done  out  1  one-cycle completion pulse.
- p0_err  out  1  with done: misaligned address or illegal funct3.
- p0_rdata  out  32  load result, valid with done.
- p1_req, p1_we, p1_funct3, p1_addr, p1_wdata, p1_gnt, p1_done, p1_err, p1_rdata  same as port 0.
- mem_read  out  1  to memory MemRead.
- mem_write  out  1  to memory MemWrite.
- mem_addr  out  32  word-aligned address; bits [1:0] always 0.
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  combinational read data from memory.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE; RR pointer favours port 0.
  - All outputs 0. Transaction registers cleared.
  - An in-flight transaction is discarded: no done, no further mem_write.
- States: IDLE, RD, WR, RMW_RD, RMW_WR, DONE.
- IDLE arbitration:
  - gnt is combinational, asserted only in IDLE; at most one gnt high.
  - Only one port requesting: that port is granted.
  - Both requesting, RR_EN=1: grant the port not granted last.
  - Both requesting, RR_EN=0: grant port 0.
  - At the grant edge, latch port id, we, funct3, addr, wdata. Update the RR pointer to the granted port.
- Legality check at grant:
  - Illegal: load funct3 011/110/111; store funct3 other than 000/001/010.
  - Illegal: halfword with addr[0]=1; word with addr[1:0]!=0.
  - Illegal requests go straight to DONE with err=1 and no memory access. rdata=0.
- Transitions:
  - Load: IDLE -> RD -> DONE.
  - SW: IDLE -> WR -> DONE.
  - SB/SH: IDLE -> RMW_RD -> RMW_WR -> DONE.
  - DONE -> IDLE always.
- Memory drive:
  - RD and RMW_RD: mem_read=1; capture mem_rdata at the state's posedge.
  - WR and RMW_WR: mem_write=1.
  - mem_read and mem_write are never high together.
  - In IDLE and DONE: mem_addr=0, mem_wdata=0.
- Store merge:
  - SB replaces byte lane addr[1:0] of the captured word with wdata[7:0].
  - SH replaces lane addr[1] (bits 15:0 or 31:16) with wdata[15:0].
  - SW writes wdata unmodified.
- Load extract: select the byte/halfword by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- DONE: assert done, rdata and err on the latched port only, for exactly one cycle. The other port's outputs stay 0.
- Latency from grant cycle T: load and SW done at T+2; SB/SH done at T+3; error done at T+1.
- Throughput: next grant no earlier than the cycle after DONE.
- Dropping req before gnt has no effect. Requests arriving while busy wait; gnt is not asserted.
- rdata is held at 0 when done=0.

Test Plan:
- Reset, then p0 SW addr 0x10 wdata 0xDEADBEEF -> p0_gnt at T; mem_write=1, mem_addr=0x10 at T+1; p0_done at T+2. Then p0 LW 0x10 -> p0_rdata=0xDEADBEEF.
- Word 0x20 = 0x11223344; p1 SB addr 0x22 wdata 0xAA -> mem_read at T+1, mem_write with mem_wdata=0x11AA3344 at T+2, p1_done at T+3. Then LB 0x22 -> 0xFFFFFFAA; LBU 0x22 -> 0x000000AA.
- SH addr 0x22 wdata 0x8001 into 0x11223344 -> word 0x80013344. Then LH 0x22 -> 0xFFFF8001; LHU 0x22 -> 0x00008001.
- p0 LW 0x13 and p1 SH 0x21 -> each gets done+err at T+1; no mem_read/mem_write; memory unchanged.
- RR_EN=1, both ports request continuously -> grants alternate p0, p1, p0, p1. RR_EN=0 -> p0 always granted while requesting.
- rst asserted in RMW_RD of SB 0x30 -> next cycle IDLE, busy=0; no mem_write; no done; word 0x30 unchanged.
